// File: rtl/syscall_engine_if.sv
// Syscall engine bundle: ID-stage trigger, data-memory read port and output character stream.
// slave is the engine side; master is the pipeline/memory/consumer side.
interface syscall_engine_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              syscall_valid;
  logic [31:0]       v0;
  logic [31:0]       a0;
  logic              sysstall;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              mem_rvalid;
  logic [7:0]        char_data;
  logic              char_valid;
  logic              char_ready;
  logic              halt;
  logic              err;

  modport slave (
    input  syscall_valid, v0, a0, mem_rdata, mem_rvalid, char_ready,
    output sysstall, mem_req, mem_addr, char_data, char_valid, halt, err
  );

  modport master (
    output syscall_valid, v0, a0, mem_rdata, mem_rvalid, char_ready,
    input  sysstall, mem_req, mem_addr, char_data, char_valid, halt, err
  );
endinterface

// File: rtl/syscall_engine.sv
// Sequential syscall service unit: print_char/print_string/print_int/exit into a buffered
// character stream, stalling ID until the service completes.
module syscall_engine #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned MAX_STR_LEN = 256,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  syscall_engine_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PW1   = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(MAX_STR_LEN + 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_PUT_CHAR, ST_STR_REQ, ST_STR_WAIT, ST_STR_PUSH,
    ST_INT_SIGN, ST_INT_DIG, ST_INT_PUSH, ST_DRAIN, ST_HALT, ST_ERR, ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        byte_q, byte_d;
  logic [31:0]       mag_q, mag_d;
  logic              neg_q, neg_d;
  logic [3:0]        pidx_q, pidx_d;
  logic [3:0]        digit_q, digit_d;
  logic              started_q, started_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              halt_q, halt_d;
  logic              err_q, err_d;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
  logic              fifo_empty, fifo_full, pop, push, can_push;
  logic [7:0]        push_data;

  function automatic logic [31:0] pow10(input logic [3:0] idx);
    case (idx)
      4'd0:    pow10 = 32'd1_000_000_000;
      4'd1:    pow10 = 32'd100_000_000;
      4'd2:    pow10 = 32'd10_000_000;
      4'd3:    pow10 = 32'd1_000_000;
      4'd4:    pow10 = 32'd100_000;
      4'd5:    pow10 = 32'd10_000;
      4'd6:    pow10 = 32'd1_000;
      4'd7:    pow10 = 32'd100;
      4'd8:    pow10 = 32'd10;
      default: pow10 = 32'd1;
    endcase
  endfunction

  // Big-endian byte lane select.
  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] off);
    case (off)
      2'd0:    sel_byte = w[31:24];
      2'd1:    sel_byte = w[23:16];
      2'd2:    sel_byte = w[15:8];
      default: sel_byte = w[7:0];
    endcase
  endfunction

  // A pop in the same cycle frees the slot, so a full FIFO still accepts that push.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop        = !fifo_empty && bus.char_ready;
  assign can_push   = !fifo_full || pop;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    byte_d    = byte_q;
    mag_d     = mag_q;
    neg_d     = neg_q;
    pidx_d    = pidx_q;
    digit_d   = digit_q;
    started_d = started_q;
    push      = 1'b0;
    push_data = byte_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.syscall_valid && !halt_q) begin
          ptr_d     = ADDR_W'(bus.a0);
          cnt_d     = '0;
          byte_d    = bus.a0[7:0];
          neg_d     = bus.a0[31];
          mag_d     = bus.a0[31] ? (32'd0 - bus.a0) : bus.a0;
          pidx_d    = 4'd0;
          digit_d   = 4'd0;
          started_d = 1'b0;
          case (bus.v0)
            32'd11:  state_d = ST_PUT_CHAR;
            32'd4:   state_d = ST_STR_REQ;
            32'd1:   state_d = ST_INT_SIGN;
            32'd10:  state_d = ST_DRAIN;
            default: state_d = ST_ERR;
          endcase
        end
      end
      ST_PUT_CHAR: begin
        if (can_push) begin
          push    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_STR_REQ: state_d = ST_STR_WAIT;
      ST_STR_WAIT: begin
        if (bus.mem_rvalid) begin
          byte_d  = sel_byte(bus.mem_rdata, ptr_q[1:0]);
          state_d = (byte_d == 8'd0) ? ST_DONE : ST_STR_PUSH;
        end
      end
      ST_STR_PUSH: begin
        if (can_push) begin
          push    = 1'b1;
          ptr_d   = ptr_q + ADDR_W'(1);
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_d == CNT_W'(MAX_STR_LEN)) ? ST_ERR : ST_STR_REQ;
        end
      end
      ST_INT_SIGN: begin
        if (!neg_q) begin
          state_d = ST_INT_DIG;
        end else if (can_push) begin
          push      = 1'b1;
          push_data = 8'h2D;
          state_d   = ST_INT_DIG;
        end
      end
      // One subtraction per cycle against the current power of ten.
      ST_INT_DIG: begin
        if (mag_q >= pow10(pidx_q)) begin
          mag_d   = mag_q - pow10(pidx_q);
          digit_d = digit_q + 4'd1;
        end else begin
          state_d = ST_INT_PUSH;
        end
      end
      ST_INT_PUSH: begin
        if (digit_q == 4'd0 && !started_q && pidx_q != 4'd9) begin
          pidx_d  = pidx_q + 4'd1;
          state_d = ST_INT_DIG;
        end else if (can_push) begin
          push      = 1'b1;
          push_data = 8'h30 + 8'(digit_q);
          started_d = 1'b1;
          digit_d   = 4'd0;
          if (pidx_q == 4'd9) begin
            state_d = ST_DONE;
          end else begin
            pidx_d  = pidx_q + 4'd1;
            state_d = ST_INT_DIG;
          end
        end
      end
      ST_DRAIN: if (fifo_empty) state_d = ST_HALT;
      ST_HALT:  state_d = ST_HALT;
      ST_ERR:   state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    mem_req_d  = (state_d == ST_STR_REQ) || (state_d == ST_STR_WAIT);
    mem_addr_d = mem_req_d ? {ptr_d[ADDR_W-1:2], 2'b00} : mem_addr_q;
    halt_d     = (state_d == ST_HALT);
    err_d      = (state_d == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      byte_q     <= '0;
      mag_q      <= '0;
      neg_q      <= 1'b0;
      pidx_q     <= '0;
      digit_q    <= '0;
      started_q  <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      halt_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      mag_q      <= mag_d;
      neg_q      <= neg_d;
      pidx_q     <= pidx_d;
      digit_q    <= digit_d;
      started_q  <= started_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      halt_q     <= halt_d;
      err_q      <= err_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW1'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW1'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= push_data;
  end

  assign bus.sysstall   = (state_q == ST_IDLE && bus.syscall_valid && !halt_q) ||
                          !(state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_HALT);
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.char_data  = fifo_mem[rd_ptr_q[PTR_W-1:0]];
  assign bus.char_valid = !fifo_empty;
  assign bus.halt       = halt_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_syscall_engine.sv
// Directed bench for syscall_engine: vector table of syscalls plus hand sequences for
// FIFO backpressure, reset mid-string and exit/halt behaviour.
module tb_syscall_engine;
  localparam int unsigned ADDR_W = 32;

  logic clk;
  logic rst_n;

  syscall_engine_if #(.ADDR_W(ADDR_W)) bus ();

  syscall_engine #(.FIFO_DEPTH(16), .MAX_STR_LEN(256), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] v0;
    logic [31:0] a0;
    logic [95:0] s;
    int          len;
    int          errs;
    int          stall;
    logic [31:0] watch;
  } vec_t;

  vec_t        vecs [13];
  logic [7:0]  mb [1024];
  logic [7:0]  got [$];
  int          err_seen, rv_cnt, addr_bad;
  int          n_tests, n_fail;
  int          mem_lat;
  bit          watch_en;
  logic [31:0] watch_addr;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int i;
    i = int'(a - 32'h1000);
    if (i < 0 || i > 1020) return 32'h0;
    return {mb[i], mb[i+1], mb[i+2], mb[i+3]};
  endfunction

  function automatic logic [127:0] packed_got(input int base);
    logic [127:0] g;
    g = '0;
    for (int i = base; i < got.size(); i++) g = {g[119:0], got[i]};
    return g;
  endfunction

  task automatic set_vec(input int i, input logic [31:0] v0, input logic [31:0] a0,
                         input logic [95:0] s, input int len, input int errs,
                         input int stall, input logic [31:0] watch);
    vecs[i].v0 = v0;     vecs[i].a0 = a0;     vecs[i].s = s;
    vecs[i].len = len;   vecs[i].errs = errs; vecs[i].stall = stall;
    vecs[i].watch = watch;
  endtask

  // Memory responder: one outstanding word read, fixed latency mem_lat.
  initial begin : mem_model
    bit          pend;
    int          lat_cnt;
    logic [31:0] pend_addr;
    pend = 1'b0;
    lat_cnt = 0;
    pend_addr = '0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_rvalid = 1'b0;
      if (pend) begin
        if (lat_cnt <= 1) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = mem_word(pend_addr);
          pend = 1'b0;
        end else begin
          lat_cnt--;
        end
      end else if (bus.mem_req) begin
        pend      = 1'b1;
        pend_addr = bus.mem_addr;
        lat_cnt   = mem_lat;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.char_valid && bus.char_ready) got.push_back(bus.char_data);
    if (bus.err) err_seen++;
    if (bus.mem_rvalid) rv_cnt++;
    if (bus.mem_req && watch_en && bus.mem_addr != watch_addr) addr_bad++;
  end

  // Hold syscall_valid like a stalled ID stage until sysstall drops (the DONE cycle).
  task automatic run_sys(input logic [31:0] v0, input logic [31:0] a0,
                         output int stall, output bit ok);
    stall = 0;
    ok = 1'b0;
    bus.syscall_valid = 1'b1;
    bus.v0 = v0;
    bus.a0 = a0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (!bus.sysstall) begin
        ok = 1'b1;
        break;
      end
      stall++;
      @(posedge clk);
      #1;
      bus.v0 = 32'd5;
      bus.a0 = 32'hFFFF_FFFF;
    end
    @(posedge clk);
    #1;
    bus.syscall_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!bus.char_valid) break;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int  stall, base, eb, rb, ab, mism;
    bit  ok;

    n_tests = 0;
    n_fail  = 0;
    err_seen = 0;
    rv_cnt = 0;
    addr_bad = 0;
    watch_en = 1'b0;
    watch_addr = '0;
    mem_lat = 3;

    for (int i = 0; i < 1024; i++) mb[i] = 8'h00;
    mb[0] = 8'h58; mb[1] = 8'h48; mb[2] = 8'h69; mb[3] = 8'h00;
    for (int i = 0; i < 20; i++) mb[256 + i] = 8'h41 + 8'(i);
    mb[512] = 8'h61; mb[513] = 8'h62; mb[514] = 8'h63; mb[515] = 8'h00;

    set_vec(0,  32'd11, 32'h0000_0041, "A",           1,  0, 2,  32'h0);
    set_vec(1,  32'd1,  32'hFFFF_FECF, "-305",        4,  0, -1, 32'h0);
    set_vec(2,  32'd1,  32'h0000_0000, "0",           1,  0, -1, 32'h0);
    set_vec(3,  32'd1,  32'h8000_0000, "-2147483648", 11, 0, -1, 32'h0);
    set_vec(4,  32'd1,  32'h7FFF_FFFF, "2147483647",  10, 0, -1, 32'h0);
    set_vec(5,  32'd1,  32'd1000000000, "1000000000", 10, 0, -1, 32'h0);
    set_vec(6,  32'd1,  32'hFFFF_FFFF, "-1",          2,  0, -1, 32'h0);
    set_vec(7,  32'd1,  32'd90210,     "90210",       5,  0, -1, 32'h0);
    set_vec(8,  32'd4,  32'h0000_1001, "Hi",          2,  0, -1, 32'h1000);
    set_vec(9,  32'd4,  32'h0000_1003, 96'h0,         0,  0, -1, 32'h1000);
    set_vec(10, 32'd5,  32'h0000_0000, 96'h0,         0,  1, 2,  32'h0);
    set_vec(11, 32'd0,  32'h0000_0000, 96'h0,         0,  1, 2,  32'h0);
    set_vec(12, 32'd4,  32'h0000_1200, "abc",         3,  0, -1, 32'h1200);

    rst_n = 1'b0;
    bus.syscall_valid = 1'b0;
    bus.v0 = '0;
    bus.a0 = '0;
    bus.char_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sysstall", bus.sysstall, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_halt", bus.halt, 0);
    check("rst_err", bus.err, 0);
    check("rst_char_valid", bus.char_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      base = got.size();
      eb = err_seen;
      ab = addr_bad;
      watch_addr = vecs[i].watch;
      watch_en = (vecs[i].watch != 32'h0);
      run_sys(vecs[i].v0, vecs[i].a0, stall, ok);
      drain();
      watch_en = 1'b0;
      check($sformatf("v%0d_done", i), ok, 1);
      check($sformatf("v%0d_len", i), got.size() - base, vecs[i].len);
      check($sformatf("v%0d_data", i), packed_got(base), {32'h0, vecs[i].s});
      check($sformatf("v%0d_err", i), err_seen - eb, vecs[i].errs);
      if (vecs[i].stall >= 0) check($sformatf("v%0d_stall", i), stall, vecs[i].stall);
      if (vecs[i].watch != 32'h0) check($sformatf("v%0d_addr", i), addr_bad - ab, 0);
    end

    // 20-char string against a blocked consumer: 16 buffered, 17th byte held in the FSM.
    base = got.size();
    rb = rv_cnt;
    bus.char_ready = 1'b0;
    bus.syscall_valid = 1'b1;
    bus.v0 = 32'd4;
    bus.a0 = 32'h0000_1100;
    repeat (300) @(posedge clk);
    @(negedge clk);
    check("full_sysstall", bus.sysstall, 1);
    check("full_fetches", rv_cnt - rb, 17);
    check("full_mem_req", bus.mem_req, 0);
    check("full_no_pop", got.size() - base, 0);
    check("full_char_valid", bus.char_valid, 1);
    @(posedge clk);
    #1;
    bus.char_ready = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (!bus.sysstall) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.syscall_valid = 1'b0;
    drain();
    check("full_done", ok, 1);
    check("full_count", got.size() - base, 20);
    mism = 0;
    for (int i = 0; i < 20 && base + i < got.size(); i++)
      if (got[base + i] != 8'h41 + 8'(i)) mism++;
    check("full_order_mismatches", mism, 0);

    // Reset while a string read is outstanding; the late rvalid must be ignored.
    mem_lat = 6;
    base = got.size();
    bus.syscall_valid = 1'b1;
    bus.v0 = 32'd4;
    bus.a0 = 32'h0000_1100;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.syscall_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_sysstall", bus.sysstall, 0);
    check("mid_rst_mem_req", bus.mem_req, 0);
    check("mid_rst_mem_addr", bus.mem_addr, 0);
    check("mid_rst_char_valid", bus.char_valid, 0);
    check("mid_rst_err", bus.err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("post_rst_mem_req", bus.mem_req, 0);
    check("post_rst_char_valid", bus.char_valid, 0);
    check("post_rst_sysstall", bus.sysstall, 0);
    check("post_rst_no_chars", got.size() - base, 0);
    @(posedge clk);
    #1;
    mem_lat = 3;
    run_sys(32'd11, 32'h0000_005A, stall, ok);
    drain();
    check("post_rst_pc_data", packed_got(base), 128'h5A);
    check("post_rst_pc_stall", stall, 2);

    // Exit must wait for the stream to drain, then halt sticks.
    base = got.size();
    bus.char_ready = 1'b0;
    run_sys(32'd4, 32'h0000_1200, stall, ok);
    check("halt_str_done", ok, 1);
    bus.syscall_valid = 1'b1;
    bus.v0 = 32'd10;
    bus.a0 = 32'h0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("drain_halt_low", bus.halt, 0);
    check("drain_sysstall", bus.sysstall, 1);
    check("drain_char_valid", bus.char_valid, 1);
    @(posedge clk);
    #1;
    bus.char_ready = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.halt) begin
        ok = 1'b1;
        break;
      end
    end
    check("halt_rise", ok, 1);
    check("halt_stream", packed_got(base), 128'h616263);
    check("halt_sysstall", bus.sysstall, 0);
    check("halt_char_valid", bus.char_valid, 0);
    @(posedge clk);
    #1;
    bus.v0 = 32'd11;
    bus.a0 = 32'h0000_005A;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("halt_sticky", bus.halt, 1);
    check("halt_ignore_sysstall", bus.sysstall, 0);
    check("halt_ignore_char", bus.char_valid, 0);
    @(posedge clk);
    #1;
    bus.syscall_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("halt_rst_clear", bus.halt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = got.size();
    run_sys(32'd11, 32'h0000_0021, stall, ok);
    drain();
    check("after_halt_pc_data", packed_got(base), 128'h21);
    check("after_halt_pc_stall", stall, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
